// File: rtl/mul_unit_seq.sv
// Iterative multiply / multiply-accumulate unit for the multi-cycle core.
// Retires BITS_PER_CYCLE multiplier bits per cycle; start/busy/done handshake.
module mul_unit_seq #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [1:0]       flags
);

  localparam int W2 = 2 * WIDTH;
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W2-1:0]   r_acc;
  logic [W2-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic            r_long;
  logic            r_busy;
  logic            r_done;
  logic [WIDTH-1:0] r_res_lo;
  logic [WIDTH-1:0] r_res_hi;
  logic [1:0]      r_flags;

  logic            w_sgn;
  logic [W2-1:0]   w_aext;
  logic [W2-1:0]   w_acc0;
  logic [W2-1:0]   w_corr;
  logic [W2-1:0]   w_pp;
  logic [W2-1:0]   w_sum;
  logic            w_last;

  assign w_sgn  = op[2] & op[1];
  assign w_aext = w_sgn ? {{WIDTH{a[WIDTH-1]}}, a}
                        : {{WIDTH{1'b0}}, a};
  assign w_acc0 = !op[0] ? '0
                : op[2]  ? {acc_hi, acc_lo}
                         : {{WIDTH{1'b0}}, acc_lo};
  // A negative multiplier has its MSB weighted -2^(W-1); the
  // unsigned loop adds +2^(W-1), so pre-subtract a*2^W.
  assign w_corr = (w_sgn && b[WIDTH-1]) ? {a, {WIDTH{1'b0}}} : '0;

  assign w_pp = r_mcand *
    {{(W2-BITS_PER_CYCLE){1'b0}}, r_mplier[BITS_PER_CYCLE-1:0]};
  assign w_sum  = r_acc + w_pp;
  assign w_last = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_long   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_flags  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_CALC;
            r_cnt    <= '0;
            r_acc    <= w_acc0 - w_corr;
            r_mcand  <= w_aext;
            r_mplier <= b;
            r_long   <= op[2];
            r_busy   <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << BITS_PER_CYCLE;
          r_mplier <= r_mplier >> BITS_PER_CYCLE;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_res_lo <= w_sum[WIDTH-1:0];
            if (r_long) begin
              r_res_hi <= w_sum[W2-1:WIDTH];
              r_flags  <= {w_sum[W2-1], w_sum == '0};
            end else begin
              r_res_hi <= '0;
              r_flags  <= {w_sum[WIDTH-1],
                           w_sum[WIDTH-1:0] == '0};
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result_lo = r_res_lo;
  assign result_hi = r_res_hi;
  assign flags     = r_flags;

endmodule
